// File: rtl/sram_arbiter.sv
// Two-port arbiter/sequencer in front of the 32-bit SRAM controller.
// Latency: request in IDLE -> strobe next cycle; ack forwarded combinationally from controller ack (write T+3, read T+6).
// Backpressure: requesters hold req+payload until their ack; one transaction in flight, others wait in IDLE.
module sram_arbiter #(
  parameter bit RR_EN   = 1'b1,
  parameter int TIMEOUT = 15
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_p0_req,
  input  logic        i_p0_we,
  input  logic [17:0] i_p0_addr,
  input  logic [31:0] i_p0_wdata,
  input  logic [3:0]  i_p0_bmask,
  output logic        o_p0_ack,
  output logic [31:0] o_p0_rdata,
  output logic        o_p0_err,
  input  logic        i_p1_req,
  input  logic        i_p1_we,
  input  logic [17:0] i_p1_addr,
  input  logic [31:0] i_p1_wdata,
  input  logic [3:0]  i_p1_bmask,
  output logic        o_p1_ack,
  output logic [31:0] o_p1_rdata,
  output logic        o_p1_err,
  output logic [17:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_bmask,
  output logic        o_mem_wren,
  output logic        o_mem_rden,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_ack,
  output logic        o_busy
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t        state_q;
  logic          owner_q;
  logic          last_q;     // last granted port; the opposite one wins the next tie
  logic [CW-1:0] cnt_q;
  logic          we_q;
  logic [17:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    bmask_q;
  logic          wren_q;
  logic          rden_q;
  logic          busy_q;

  logic          any_req;
  logic          sel_d;
  logic          we_d;
  logic [17:0]   addr_d;
  logic [31:0]   wdata_d;
  logic [3:0]    bmask_d;

  logic          at_limit;
  logic          done;
  logic          tmo;
  logic [31:0]   rsp_rdata;

  // Pick the winner among current requesters and mux its payload for capture.
  always_comb begin
    any_req = i_p0_req | i_p1_req;
    sel_d   = 1'b0;
    if (i_p0_req && i_p1_req) begin
      sel_d = RR_EN ? ~last_q : 1'b0;
    end else begin
      sel_d = i_p1_req;
    end
    we_d    = sel_d ? i_p1_we    : i_p0_we;
    addr_d  = sel_d ? i_p1_addr  : i_p0_addr;
    wdata_d = sel_d ? i_p1_wdata : i_p0_wdata;
    bmask_d = sel_d ? i_p1_bmask : i_p0_bmask;
  end

  // A genuine controller ack beats a timeout landing in the same cycle.
  assign at_limit  = (cnt_q == TO_LIMIT);
  assign done      = (state_q == WAIT) && (i_mem_ack || at_limit);
  assign tmo       = (state_q == WAIT) && !i_mem_ack && at_limit;
  assign rsp_rdata = tmo ? 32'h0 : i_mem_rdata;

  assign o_p0_ack   = done & ~owner_q;
  assign o_p0_err   = tmo  & ~owner_q;
  assign o_p0_rdata = o_p0_ack ? rsp_rdata : 32'h0;
  assign o_p1_ack   = done & owner_q;
  assign o_p1_err   = tmo  & owner_q;
  assign o_p1_rdata = o_p1_ack ? rsp_rdata : 32'h0;

  // Payload registers drive the controller bus; strobes are only high in ISSUE.
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_bmask = bmask_q;
  assign o_mem_wren  = wren_q;
  assign o_mem_rden  = rden_q;
  assign o_busy      = busy_q;

  // Arbitration FSM: capture winner in IDLE, strobe for one cycle, then wait for ack or timeout.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      bmask_q <= '0;
      wren_q  <= 1'b0;
      rden_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q <= ISSUE;
            owner_q <= sel_d;
            last_q  <= sel_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            bmask_q <= bmask_d;
            wren_q  <= we_d;
            rden_q  <= ~we_d;
            busy_q  <= 1'b1;
          end
        end
        ISSUE: begin
          wren_q  <= 1'b0;
          rden_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (done) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          wren_q  <= 1'b0;
          rden_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed vector table, multi-cycle corner sequences and
// a randomized run against a transaction-level model of the arbitration rules.
module tb_sram_arbiter;

  localparam int TO = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic        we;
    logic [17:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bmask;
  } preq_t;

  typedef struct {
    bit          port;
    bit          we;
    logic [17:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bmask;
    bit          stuck;
    int          lat;
    bit          err;
    logic [31:0] rdata;
  } vec_t;

  logic        rst_n;
  preq_t       pin [2];
  preq_t       fin [2];
  logic [1:0]  ack, err, fack, ferr;
  logic [31:0] rdata [2];
  logic [31:0] frdata [2];
  logic [17:0] d_addr, f_addr;
  logic [31:0] d_wdata, f_wdata;
  logic [3:0]  d_bmask, f_bmask;
  logic        d_wren, d_rden, f_wren, f_rden, busy, fbusy;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  sram_arbiter #(.RR_EN(1'b1), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_p0_req(pin[0].req), .i_p0_we(pin[0].we), .i_p0_addr(pin[0].addr),
    .i_p0_wdata(pin[0].wdata), .i_p0_bmask(pin[0].bmask),
    .o_p0_ack(ack[0]), .o_p0_rdata(rdata[0]), .o_p0_err(err[0]),
    .i_p1_req(pin[1].req), .i_p1_we(pin[1].we), .i_p1_addr(pin[1].addr),
    .i_p1_wdata(pin[1].wdata), .i_p1_bmask(pin[1].bmask),
    .o_p1_ack(ack[1]), .o_p1_rdata(rdata[1]), .o_p1_err(err[1]),
    .o_mem_addr(d_addr), .o_mem_wdata(d_wdata), .o_mem_bmask(d_bmask),
    .o_mem_wren(d_wren), .o_mem_rden(d_rden),
    .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack), .o_busy(busy)
  );

  sram_arbiter #(.RR_EN(1'b0), .TIMEOUT(TO)) dut_f (
    .i_clk(clk), .i_reset(rst_n),
    .i_p0_req(fin[0].req), .i_p0_we(fin[0].we), .i_p0_addr(fin[0].addr),
    .i_p0_wdata(fin[0].wdata), .i_p0_bmask(fin[0].bmask),
    .o_p0_ack(fack[0]), .o_p0_rdata(frdata[0]), .o_p0_err(ferr[0]),
    .i_p1_req(fin[1].req), .i_p1_we(fin[1].we), .i_p1_addr(fin[1].addr),
    .i_p1_wdata(fin[1].wdata), .i_p1_bmask(fin[1].bmask),
    .o_p1_ack(fack[1]), .o_p1_rdata(frdata[1]), .o_p1_err(ferr[1]),
    .o_mem_addr(f_addr), .o_mem_wdata(f_wdata), .o_mem_bmask(f_bmask),
    .o_mem_wren(f_wren), .o_mem_rden(f_rden),
    .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack), .o_busy(fbusy)
  );

  int nvec = 0;
  int nmis = 0;
  int cyc  = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Controller model: write ack 2 cycles after strobe, read ack 5 cycles after.
  int          ctl_ack_at = -1;
  logic [31:0] ctl_rd = 32'h0;
  bit          ctl_stuck = 1'b0;
  int          force_at = -1;
  logic [31:0] force_dat = 32'h0;
  bit          spur_next = 1'b0;
  logic [31:0] ctl_mem [logic [17:0]];
  logic [31:0] ref_mem [logic [17:0]];

  int ord[$];
  bit ovl;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] crd(input logic [17:0] a);
    return ctl_mem.exists(a) ? ctl_mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] rrd(input logic [17:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  task automatic mem_tick();
    logic [17:0] a;
    logic [31:0] wd;
    logic [3:0]  bm;
    logic        hit;
    a  = (d_wren | d_rden) ? d_addr  : f_addr;
    wd = (d_wren | d_rden) ? d_wdata : f_wdata;
    bm = (d_wren | d_rden) ? d_bmask : f_bmask;
    if (!rst_n) ctl_ack_at = -1;
    else if (!ctl_stuck && (d_wren | f_wren)) begin
      ctl_mem[a] = merge(crd(a), wd, bm);
      ctl_rd = 32'h0;
      ctl_ack_at = cyc + 2;
    end else if (!ctl_stuck && (d_rden | f_rden)) begin
      ctl_rd = crd(a);
      ctl_ack_at = cyc + 5;
    end
    hit = (cyc == ctl_ack_at);
    mem_ack = hit | (cyc == force_at) | spur_next;
    mem_rdata = (cyc == force_at) ? force_dat : (hit ? ctl_rd : $urandom);
  endtask

  // One clock: advance to the falling edge, update the controller, settle.
  task automatic cycle();
    @(negedge clk);
    mem_tick();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    force_at = -1;
    ctl_stuck = 1'b0;
    spur_next = 1'b0;
  endtask

  task automatic drive(input bit fp, input int p, input logic rq, input logic [17:0] ad);
    preq_t r;
    r = '{rq, 1'b0, ad, 32'h0, 4'h0};
    if (fp) fin[p] = r;
    else pin[p] = r;
  endtask

  // Both ports issue reads until each has completed its count; records ack order.
  task automatic run_pair(input bit fp, input int n0, input int n1);
    int left[2];
    int last_ack;
    bit outst;
    logic s;
    logic [1:0] a;
    left[0] = n0; left[1] = n1;
    ord.delete(); ovl = 1'b0; outst = 1'b0; last_ack = -10;
    for (int p = 0; p < 2; p++) drive(fp, p, left[p] > 0, 18'(p * 16 + left[p]));
    for (int k = 0; k < 400 && (left[0] + left[1]) > 0; k++) begin
      cycle();
      s = fp ? (f_wren | f_rden) : (d_wren | d_rden);
      a = fp ? fack : ack;
      if (s && (outst || cyc < last_ack + 2)) ovl = 1'b1;
      if (s) outst = 1'b1;
      if (a != 2'b00) begin outst = 1'b0; last_ack = cyc; end
      for (int p = 0; p < 2; p++) begin
        if (a[p]) begin
          ord.push_back(p);
          left[p]--;
          drive(fp, p, left[p] > 0, 18'(p * 16 + left[p]));
        end
      end
    end
    for (int p = 0; p < 2; p++) drive(fp, p, 1'b0, 18'h0);
  endtask

  initial begin
    #1000000;
    nmis++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt [8];
    vec_t        v;
    int          t, sc, ac, x;
    logic        sw, ea, oa, eb, eack, w;
    logic [17:0] sa;
    logic [31:0] rs, er;
    bit          e_act, e_own, e_last, e_we, e_stk;
    int          e_is, e_ak;
    logic [17:0] e_ad;
    logic [31:0] e_wd, e_rdat;
    logic [3:0]  e_bm;

    vt[0] = '{1'b0, 1'b1, 18'h00010, 32'hDEADBEEF, 4'hF, 1'b0, 3,  1'b0, 32'h0};
    vt[1] = '{1'b1, 1'b0, 18'h00010, 32'h0,        4'h0, 1'b0, 6,  1'b0, 32'hDEADBEEF};
    vt[2] = '{1'b0, 1'b1, 18'h00020, 32'h11223344, 4'h5, 1'b0, 3,  1'b0, 32'h0};
    vt[3] = '{1'b1, 1'b0, 18'h00020, 32'h0,        4'h0, 1'b0, 6,  1'b0, 32'h00220044};
    vt[4] = '{1'b0, 1'b0, 18'h00030, 32'h0,        4'h0, 1'b1, 17, 1'b1, 32'h0};
    vt[5] = '{1'b1, 1'b0, 18'h00010, 32'h0,        4'h0, 1'b0, 6,  1'b0, 32'hDEADBEEF};
    vt[6] = '{1'b1, 1'b1, 18'h3FFFF, 32'hA5A5A5A5, 4'hF, 1'b0, 3,  1'b0, 32'h0};
    vt[7] = '{1'b0, 1'b0, 18'h3FFFF, 32'h0,        4'h0, 1'b0, 6,  1'b0, 32'hA5A5A5A5};

    for (int p = 0; p < 2; p++) begin
      pin[p] = '{1'b0, 1'b0, 18'h0, 32'h0, 4'h0};
      fin[p] = '{1'b0, 1'b0, 18'h0, 32'h0, 4'h0};
    end
    mem_ack = 1'b0;
    mem_rdata = 32'h0;

    // Reset state
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_wren", d_wren, 0);
    chk("rst_rden", d_rden, 0);
    chk("rst_addr", d_addr, 0);
    chk("rst_wdata", d_wdata, 0);
    chk("rst_bmask", d_bmask, 0);
    chk("rst_ack_err", {ack, err}, 0);
    chk("rst_rdata", {rdata[0], rdata[1]}, 0);

    // Directed single transactions
    for (int i = 0; i < 8; i++) begin
      v = vt[i];
      ctl_stuck = v.stuck;
      pin[v.port] = '{1'b1, v.we, v.addr, v.wdata, v.bmask};
      t = cyc; sc = -1; ac = -1; oa = 1'b0;
      for (int k = 0; k < 40 && ac < 0; k++) begin
        cycle();
        if ((d_wren | d_rden) && sc < 0) begin sc = cyc; sw = d_wren; sa = d_addr; end
        if (ack[!v.port] | err[!v.port]) oa = 1'b1;
        if (ack[v.port]) begin ac = cyc; ea = err[v.port]; rs = rdata[v.port]; end
      end
      pin[v.port].req = 1'b0;
      chk($sformatf("v%0d_ack_latency", i), ac - t, v.lat);
      chk($sformatf("v%0d_strobe_latency", i), sc - t, 1);
      chk($sformatf("v%0d_strobe_is_write", i), sw, v.we);
      chk($sformatf("v%0d_strobe_addr", i), sa, v.addr);
      chk($sformatf("v%0d_err", i), ea, v.err);
      chk($sformatf("v%0d_rdata", i), rs, v.rdata);
      chk($sformatf("v%0d_other_port_quiet", i), oa, 0);
      ctl_stuck = 1'b0;
      cycle();
    end

    // Controller ack lands in the very cycle the timeout fires: ack wins
    ctl_stuck = 1'b1;
    pin[1] = '{1'b1, 1'b0, 18'h00040, 32'h0, 4'h0};
    t = cyc; ac = -1;
    force_at = t + 2 + TO;
    force_dat = 32'hCAFEF00D;
    for (int k = 0; k < 40 && ac < 0; k++) begin
      cycle();
      if (ack[1]) begin ac = cyc; ea = err[1]; rs = rdata[1]; end
    end
    pin[1].req = 1'b0;
    chk("tie_ack_latency", ac - t, 2 + TO);
    chk("tie_err", ea, 0);
    chk("tie_rdata", rs, 32'hCAFEF00D);
    force_at = -1; ctl_stuck = 1'b0;
    cycle();

    // Reset in the middle of a read
    pin[0] = '{1'b1, 1'b0, 18'h00010, 32'h0, 4'h0};
    cycle(); cycle(); cycle();
    chk("midrst_busy_before", busy, 1);
    rst_n = 1'b0;
    pin[0].req = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("midrst_busy", busy, 0);
    chk("midrst_strobes", {d_wren, d_rden}, 0);
    chk("midrst_bus", {d_addr, d_wdata, d_bmask}, 0);
    oa = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (ack != 2'b00 || err != 2'b00) oa = 1'b1;
      cycle();
    end
    chk("midrst_no_ack", oa, 0);
    pin[0] = '{1'b1, 1'b1, 18'h00055, 32'h12345678, 4'hF};
    t = cyc; ac = -1;
    for (int k = 0; k < 20 && ac < 0; k++) begin
      cycle();
      if (ack[0]) begin ac = cyc; ea = err[0]; end
    end
    pin[0].req = 1'b0;
    chk("midrst_write_latency", ac - t, 3);
    chk("midrst_write_err", ea, 0);
    cycle();

    // Round robin, both ports hold 4 reads each
    do_reset();
    run_pair(1'b0, 4, 4);
    chk("rr_count", ord.size(), 8);
    for (int i = 0; i < 8; i++) chk($sformatf("rr_order%0d", i), (i < ord.size()) ? ord[i] : 9, i % 2);
    chk("rr_no_overlap", ovl, 0);

    // Fixed priority: p0 keeps winning while it requests
    run_pair(1'b1, 3, 1);
    chk("fp_count", ord.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("fp_order%0d", i), (i < ord.size()) ? ord[i] : 9, (i == 3) ? 1 : 0);
    chk("fp_no_overlap", ovl, 0);

    // Randomized traffic against the transaction model
    do_reset();
    ref_mem = ctl_mem;
    e_act = 1'b0; e_last = 1'b1; e_own = 1'b0; e_we = 1'b0; e_stk = 1'b0;
    e_is = 0; e_ak = 0; e_ad = '0; e_wd = '0; e_bm = '0; e_rdat = '0;
    for (int n = 0; n < 3000; n++) begin
      cycle();
      x = cyc;
      eb = e_act && x >= e_is && x <= e_ak;
      chk("rnd_busy", busy, eb);
      chk("rnd_wren", d_wren, e_act && x == e_is && e_we);
      chk("rnd_rden", d_rden, e_act && x == e_is && !e_we);
      if (e_act && x == e_is) chk("rnd_bus", {d_addr, d_wdata, d_bmask}, {e_ad, e_wd, e_bm});
      for (int p = 0; p < 2; p++) begin
        eack = e_act && x == e_ak && e_own == p;
        er = (eack && !e_stk && !e_we) ? e_rdat : 32'h0;
        chk($sformatf("rnd_p%0d_ack", p), ack[p], eack);
        chk($sformatf("rnd_p%0d_err", p), err[p], eack && e_stk);
        chk($sformatf("rnd_p%0d_rdata", p), rdata[p], er);
        if (eack) pin[p].req = 1'b0;
      end
      for (int p = 0; p < 2; p++) begin
        if (!pin[p].req && $urandom % 3 == 0)
          pin[p] = '{1'b1, 1'($urandom), 18'($urandom_range(0, 15)), $urandom, 4'($urandom)};
        else if (pin[p].req && eb && e_own == p && x >= e_is && x != e_ak && $urandom % 4 == 0) begin
          pin[p].addr = 18'($urandom);
          pin[p].wdata = $urandom;
          pin[p].we = 1'($urandom);
        end
      end
      if (!eb && (pin[0].req || pin[1].req)) begin
        w = (pin[0].req && pin[1].req) ? !e_last : pin[1].req;
        e_act = 1'b1; e_own = w; e_last = w;
        e_we = pin[w].we; e_ad = pin[w].addr; e_wd = pin[w].wdata; e_bm = pin[w].bmask;
        e_stk = ($urandom % 12 == 0);
        ctl_stuck = e_stk;
        e_is = x + 1;
        e_ak = e_stk ? x + 2 + TO : x + 1 + (e_we ? 2 : 5);
        if (!e_stk && e_we) ref_mem[e_ad] = merge(rrd(e_ad), e_wd, e_bm);
        if (!e_stk && !e_we) e_rdat = rrd(e_ad);
      end
      spur_next = !(e_act && (x + 1) > e_is && (x + 1) <= e_ak) && ($urandom % 6 == 0);
    end
    spur_next = 1'b0;
    ctl_stuck = 1'b0;
    pin[0].req = 1'b0;
    pin[1].req = 1'b0;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-port arbiter and sequencer in front of the 32-bit SRAM controller (write ack 2 cycles after issue, read ack 5 cycles after issue).
- Accepts requests from port 0 (LSU) and port 1 (instruction/DMA side) and grants one at a time.
- Issues each granted request to the controller as a single-cycle strobe, waits for the controller ack, then routes ack, read data and timeout error back to the owner.

Parameters:
- RR_EN, 1, 1 = round-robin on simultaneous requests; 0 = fixed priority, port 0 wins.
- TIMEOUT, 15, maximum WAIT cycles before an abort; range 1..255; counter width is $clog2(TIMEOUT+1).

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-low reset
- i_p0_req  in  1  port 0 request; held with payload stable until o_p0_ack
- i_p0_we  in  1  1 = write, 0 = read
- i_p0_addr  in  18  SRAM half-word address
- i_p0_wdata  in  32  write data
- i_p0_bmask  in  4  byte mask
- o_p0_ack  out  1  one-cycle completion pulse
- o_p0_rdata  out  32  read data, valid when o_p0_ack=1
- o_p0_err  out  1  timeout pulse, coincident with o_p0_ack
- i_p1_*, o_p1_*  same set as port 0, for port 1
- o_mem_addr  out  18  to controller i_ADDR
- o_mem_wdata  out  32  to controller i_WDATA
- o_mem_bmask  out  4  to controller i_BMASK
- o_mem_wren  out  1  to controller i_WREN
- o_mem_rden  out  1  to controller i_RDEN
- i_mem_rdata  in  32  from controller o_RDATA
- i_mem_ack  in  1  from controller o_ACK
- o_busy  out  1  arbiter not in IDLE

Behaviour:
- Reset (i_reset=0 at posedge): state=IDLE, owner=0, RR pointer=1 (port 0 wins first tie), timeout counter=0, payload registers=0.
- Reset values of outputs: all o_mem_* =0, all acks/errs =0, o_busy=0.
- Reset mid-operation aborts the transaction with no ack. The controller shares the same reset.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - No request: stay in IDLE.
  - Any i_pN_req=1: select a winner, register owner and the winner's payload, go to ISSUE.
  - Both requesting, RR_EN=1: winner is the port opposite the last granted one. Pointer updates on grant.
  - Both requesting, RR_EN=0: winner is port 0.
- ISSUE (exactly 1 cycle):
  - o_mem_addr/wdata/bmask come from registers.
  - o_mem_wren = we_q; o_mem_rden = ~we_q.
  - Clear the timeout counter; go to WAIT.
- o_mem_wren and o_mem_rden are 0 in every state other than ISSUE. They are never both 1.
- The payload registers hold their value through WAIT.
- WAIT:
  - Counter increments each cycle.
  - i_mem_ack=1: o_pOWNER_ack=1 combinationally, o_pOWNER_rdata=i_mem_rdata, err=0; next state IDLE.
  - Counter reaches TIMEOUT with no ack: o_pOWNER_ack=1, o_pOWNER_err=1, rdata=0; next state IDLE.
  - i_mem_ack=1 in the same cycle as the timeout: ack wins, err=0.
- Non-owner port: ack, err and rdata are 0.
- Latency (req first high in cycle T, arbiter idle):
  - Write: ack in T+3.
  - Read: ack in T+6.
- Requester protocol:
  - Deassert req, or change the payload for a new request, in the cycle after ack.
  - A req still high in IDLE is treated as a new request.
- Back-to-back transactions: minimum 1 IDLE cycle between an ack and the next ISSUE. No request is issued while the controller is busy.
- Payload changed while req is held and before ack: ignored, since the registered copy is used.
- i_mem_ack in IDLE or ISSUE: ignored; no ack is forwarded.

Test Plan:
- Single write: p0 we=1, addr=0x00010, wdata=0xDEADBEEF, bmask=0xF at T.
  - Expect o_mem_wren=1 only in T+1, with o_mem_addr=0x00010.
  - Expect o_p0_ack in T+3, err=0.
- Single read: p1 read addr=0x00010 after the write above; controller model returns 0xDEADBEEF.
  - Expect o_mem_rden pulse at T+1.
  - Expect o_p1_ack with rdata=0xDEADBEEF at T+6; o_p0_ack stays 0.
- Simultaneous requests, RR_EN=1: both ports hold 4 reads each.
  - Grant order must be p0,p1,p0,p1,...
  - No overlap: every ISSUE follows the previous ack.
- Simultaneous requests, RR_EN=0: both held.
  - p0 is served repeatedly while it requests; p1 is granted only once p0 deasserts.
- Timeout: mem ack stuck at 0, TIMEOUT=15, p0 read.
  - Expect o_p0_ack=1, o_p0_err=1, rdata=0 after 15 WAIT cycles, then IDLE.
  - A subsequent p1 request must be served normally.
- Reset mid-read: assert i_reset=0 during WAIT.
  - Next cycle: o_busy=0, no ack emitted, all o_mem_*=0.
  - After release, a fresh p0 write completes in 3 cycles.
